// File: rtl/dlx_pkg.sv
// Shared DLX definitions: opcodes, data-memory responder FSM encodings, word width.
package dlx_pkg;

  localparam int WORD_W = 32;

  localparam logic [5:0] LW = 6'b000101;
  localparam logic [5:0] SW = 6'b001010;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] WAIT = 2'b01;
  localparam logic [1:0] RESP = 2'b10;

endpackage

// File: rtl/datamem_array.sv
// Word-addressed storage: single address port, synchronous write, combinational read.
// Storage is deliberately not reset so contents survive a responder reset.
module datamem_array
  import dlx_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clockm,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [WORD_W-1:0]     wdata,
  output logic [WORD_W-1:0]     rdata
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WORD_W-1:0] mem [DEPTH];

  // Commit a word on the write-enabled edge.
  always_ff @(posedge clockm) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  // Read is asynchronous so the response register can capture it directly.
  assign rdata = mem[addr];

endmodule

// File: rtl/datamem_resp.sv
// Data-memory responder for the MEM stage: accepts one word request at a time,
// waits WAIT_STATES cycles, then answers with a single-cycle memready pulse.
//
// Handshake: a request is accepted on any rising edge where the FSM is IDLE and
// memrd|memwr is high; membusy rises after that edge and stays high through the
// RESP cycle. memready is high for exactly one cycle; memerr and readmemdata are
// only meaningful while memready is high. The requester drops its strobes during
// RESP; a strobe still high in the following IDLE cycle starts a new request.
module datamem_resp
  import dlx_pkg::*;
#(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_STATES = 2
) (
  input  logic              clockm,
  input  logic              resetm,
  input  logic [31:0]       memaddress,
  input  logic [31:0]       memwrdata,
  input  logic              memrd,
  input  logic              memwr,
  output logic [31:0]       readmemdata,
  output logic              memready,
  output logic              memerr,
  output logic              membusy,
  output logic [1:0]        dbg_state
);

  logic [1:0]            state;
  logic [1:0]            next_state;
  logic [3:0]            count;
  logic [DEPTH_LOG2-1:0] lat_idx;
  logic [WORD_W-1:0]     lat_data;
  logic                  lat_wr;
  logic                  lat_err;

  logic                  accept;
  logic                  err_now;
  logic [DEPTH_LOG2-1:0] idx_now;
  logic                  err_sel;
  logic                  wr_sel;
  logic [DEPTH_LOG2-1:0] idx_sel;
  logic                  arr_we;
  logic [WORD_W-1:0]     arr_rdata;

  assign dbg_state = state;
  assign accept    = (state == IDLE) && (memrd || memwr);
  assign idx_now   = memaddress[DEPTH_LOG2+1:2];

  // Illegal access: misaligned, beyond the array, or both strobes at once.
  always_comb begin
    err_now = 1'b0;
    if (memaddress[1:0] != 2'b00) err_now = 1'b1;
    if ((memaddress >> (DEPTH_LOG2 + 2)) != 32'd0) err_now = 1'b1;
    if (memrd && memwr) err_now = 1'b1;
  end

  // With zero wait states RESP is entered straight from IDLE, before the latches
  // are loaded, so the live inputs stand in for the latched request on that edge.
  always_comb begin
    if (state == IDLE) begin
      err_sel = err_now;
      wr_sel  = memwr;
      idx_sel = idx_now;
    end else begin
      err_sel = lat_err;
      wr_sel  = lat_wr;
      idx_sel = lat_idx;
    end
  end

  // Writes land on the edge that closes the RESP cycle, never for a rejected access.
  assign arr_we = (state == RESP) && lat_wr && !lat_err;

  // Next-state selection for the IDLE -> WAIT -> RESP -> IDLE sequence.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) next_state = (WAIT_STATES > 0) ? WAIT : RESP;
      end
      WAIT: begin
        if (count == 4'd1) next_state = RESP;
      end
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State, request latches, wait counter and registered outputs.
  always_ff @(posedge clockm or posedge resetm) begin
    if (resetm) begin
      state       <= IDLE;
      count       <= 4'd0;
      lat_idx     <= '0;
      lat_data    <= '0;
      lat_wr      <= 1'b0;
      lat_err     <= 1'b0;
      readmemdata <= '0;
      memready    <= 1'b0;
      memerr      <= 1'b0;
      membusy     <= 1'b0;
    end else begin
      state <= next_state;

      case (state)
        IDLE: begin
          if (accept) begin
            lat_idx  <= idx_now;
            lat_data <= memwrdata;
            lat_wr   <= memwr;
            lat_err  <= err_now;
            count    <= 4'(WAIT_STATES);
          end
        end
        WAIT:    count <= count - 4'd1;
        default: count <= count;
      endcase

      memready <= (next_state == RESP);
      memerr   <= (next_state == RESP) && err_sel;
      membusy  <= (next_state != IDLE);

      // Capture read data on the edge entering RESP; otherwise hold the last read.
      if ((next_state == RESP) && !err_sel && !wr_sel) begin
        readmemdata <= arr_rdata;
      end
    end
  end

  datamem_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .clockm(clockm),
    .we    (arr_we),
    .addr  (idx_sel),
    .wdata (lat_data),
    .rdata (arr_rdata)
  );

endmodule

// File: tb/tb_datamem_resp.sv
// Directed bench for datamem_resp: a vector table against the default build
// (WAIT_STATES=2) plus hand sequences for reset-during-wait and a zero-wait build.
module tb_datamem_resp;

  localparam int WS0 = 2;

  logic        clockm = 1'b0;
  logic        resetm;
  logic [31:0] memaddress, memwrdata;
  logic        memrd, memwr;
  logic [31:0] readmemdata;
  logic        memready, memerr, membusy;
  logic [1:0]  dbg_state;

  logic [31:0] memaddress1, memwrdata1;
  logic        memrd1, memwr1;
  logic [31:0] readmemdata1;
  logic        memready1, memerr1, membusy1;
  logic [1:0]  dbg_state1;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] last_rd = 32'd0;

  // Clock
  always #5 clockm = ~clockm;

  datamem_resp #(.DEPTH_LOG2(10), .WAIT_STATES(WS0)) dut (
    .clockm(clockm), .resetm(resetm), .memaddress(memaddress), .memwrdata(memwrdata),
    .memrd(memrd), .memwr(memwr), .readmemdata(readmemdata), .memready(memready),
    .memerr(memerr), .membusy(membusy), .dbg_state(dbg_state)
  );

  datamem_resp #(.DEPTH_LOG2(10), .WAIT_STATES(0)) dut0 (
    .clockm(clockm), .resetm(resetm), .memaddress(memaddress1), .memwrdata(memwrdata1),
    .memrd(memrd1), .memwr(memwr1), .readmemdata(readmemdata1), .memready(memready1),
    .memerr(memerr1), .membusy(membusy1), .dbg_state(dbg_state1)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
    logic        toggle;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rd, logic wr, logic [31:0] addr, logic [31:0] wdata,
                              logic exp_err, logic [31:0] exp_rdata, logic toggle);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata;
    v.exp_err = exp_err; v.exp_rdata = exp_rdata; v.toggle = toggle;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // One request on the WAIT_STATES=2 instance, checked end to end.
  task automatic run_vec(input vec_t v);
    int lat;
    @(negedge clockm);
    memaddress = v.addr; memwrdata = v.wdata; memrd = v.rd; memwr = v.wr;
    @(posedge clockm); #1;
    memrd = 1'b0; memwr = 1'b0;
    if (v.toggle) begin
      memaddress = 32'h0000_0020;
      memwrdata  = 32'h5A5A_5A5A;
    end
    check("busy_after_accept", {31'd0, membusy}, 32'd1);
    lat = 1;
    while (!memready && lat < 20) begin
      @(posedge clockm); #1;
      lat++;
    end
    check("latency", lat, WS0 + 1);
    check("busy_in_resp", {31'd0, membusy}, 32'd1);
    check("memerr", {31'd0, memerr}, {31'd0, v.exp_err});
    if (!v.exp_err && v.rd && !v.wr) last_rd = v.exp_rdata;
    check("readmemdata", readmemdata, last_rd);
    @(posedge clockm); #1;
    check("ready_pulse_end", {31'd0, memready}, 32'd0);
    check("err_low_idle", {31'd0, memerr}, 32'd0);
    check("busy_end", {31'd0, membusy}, 32'd0);
  endtask

  initial begin
    resetm = 1'b1;
    memaddress = '0; memwrdata = '0; memrd = 1'b0; memwr = 1'b0;
    memaddress1 = '0; memwrdata1 = '0; memrd1 = 1'b0; memwr1 = 1'b0;

    // Vector table: {rd, wr, addr, wdata, exp_err, exp_rdata, toggle}
    vecs.push_back(mk(0, 1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 32'h0, 0));
    vecs.push_back(mk(1, 0, 32'h0000_0010, 32'h0,         0, 32'hDEAD_BEEF, 0));
    vecs.push_back(mk(0, 1, 32'h0000_0000, 32'h1111_1111, 0, 32'h0, 0));
    vecs.push_back(mk(0, 1, 32'h0000_0040, 32'hCAFE_F00D, 0, 32'h0, 0));
    vecs.push_back(mk(0, 1, 32'h0000_0020, 32'h2020_2020, 0, 32'h0, 0));
    vecs.push_back(mk(1, 0, 32'h0000_0012, 32'h0,         1, 32'h0, 0));
    vecs.push_back(mk(1, 0, 32'h0000_0010, 32'h0,         0, 32'hDEAD_BEEF, 0));
    vecs.push_back(mk(0, 1, 32'h0000_1000, 32'hAAAA_5555, 1, 32'h0, 0));
    vecs.push_back(mk(1, 0, 32'h0000_0000, 32'h0,         0, 32'h1111_1111, 0));
    vecs.push_back(mk(1, 1, 32'h0000_0000, 32'hBAD0_BAD0, 1, 32'h0, 0));
    vecs.push_back(mk(1, 0, 32'h0000_0000, 32'h0,         0, 32'h1111_1111, 0));
    vecs.push_back(mk(0, 1, 32'h0000_0004, 32'h0BAD_CAFE, 0, 32'h0, 1));
    vecs.push_back(mk(1, 0, 32'h0000_0004, 32'h0,         0, 32'h0BAD_CAFE, 0));
    vecs.push_back(mk(1, 0, 32'h0000_0020, 32'h0,         0, 32'h2020_2020, 0));
    vecs.push_back(mk(1, 0, 32'h0000_0010, 32'h0,         0, 32'hDEAD_BEEF, 1));
    vecs.push_back(mk(0, 1, 32'h0000_0FFC, 32'h0FFC_0FFC, 0, 32'h0, 0));
    vecs.push_back(mk(1, 0, 32'h0000_0FFC, 32'h0,         0, 32'h0FFC_0FFC, 0));
    vecs.push_back(mk(1, 0, 32'h8000_0000, 32'h0,         1, 32'h0, 0));
    vecs.push_back(mk(1, 0, 32'h0000_0003, 32'h0,         1, 32'h0, 0));

    // Reset state
    repeat (2) @(posedge clockm);
    @(negedge clockm);
    check("rst_ready", {31'd0, memready}, 32'd0);
    check("rst_busy", {31'd0, membusy}, 32'd0);
    check("rst_err", {31'd0, memerr}, 32'd0);
    check("rst_rdata", readmemdata, 32'd0);
    check("rst_state", {30'd0, dbg_state}, 32'd0);
    resetm = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset during WAIT abandons a pending write.
    @(negedge clockm);
    memaddress = 32'h0000_0040; memwrdata = 32'h1234_5678; memwr = 1'b1;
    @(posedge clockm); #1;
    memwr = 1'b0;
    check("midrst_busy", {31'd0, membusy}, 32'd1);
    @(posedge clockm); #1;
    resetm = 1'b1;
    #1;
    check("midrst_ready", {31'd0, memready}, 32'd0);
    check("midrst_busy0", {31'd0, membusy}, 32'd0);
    check("midrst_err", {31'd0, memerr}, 32'd0);
    check("midrst_rdata", readmemdata, 32'd0);
    check("midrst_state", {30'd0, dbg_state}, 32'd0);
    repeat (3) begin
      @(negedge clockm);
      check("midrst_no_resp", {31'd0, memready}, 32'd0);
    end
    resetm = 1'b0;
    last_rd = 32'd0;
    run_vec(mk(1, 0, 32'h0000_0040, 32'h0, 0, 32'hCAFE_F00D, 0));

    // Zero-wait build with strobes held high: a response every second cycle.
    @(negedge clockm);
    memaddress1 = 32'h0000_0100; memwrdata1 = 32'hA000_0000; memwr1 = 1'b1; memrd1 = 1'b0;
    for (int j = 0; j < 8; j++) begin
      @(negedge clockm);
      check("z_ready", {31'd0, memready1}, 32'd1);
      check("z_err", {31'd0, memerr1}, 32'd0);
      check("z_busy", {31'd0, membusy1}, 32'd1);
      if (j % 2 == 1) check("z_rdata", readmemdata1, 32'hA000_0000 + 32'(j / 2));
      if (j == 7) begin
        memrd1 = 1'b0; memwr1 = 1'b0;
      end else if (j % 2 == 0) begin
        memwr1 = 1'b0; memrd1 = 1'b1;
      end else begin
        memrd1 = 1'b0; memwr1 = 1'b1;
        memaddress1 = 32'h0000_0100 + 32'((j / 2 + 1) * 8);
        memwrdata1  = 32'hA000_0000 + 32'(j / 2 + 1);
      end
      @(negedge clockm);
      check("z_gap", {31'd0, memready1}, 32'd0);
    end
    @(negedge clockm);
    check("z_idle", {31'd0, memready1}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
